// File: rtl/legv8_pkg.sv
// LEGv8 immediate-format codes, opcode constants and the R-type exemption list.
package legv8_pkg;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_D    = 3'd1,
        FMT_I    = 3'd2,
        FMT_CB   = 3'd3,
        FMT_B    = 3'd4,
        FMT_IM   = 3'd5
    } imm_fmt_e;

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } occ_e;

    // D-format, instr[31:21]
    localparam logic [10:0] OP_LDUR   = 11'h7C2;
    localparam logic [10:0] OP_STUR   = 11'h7C0;
    localparam logic [10:0] OP_LDURB  = 11'h1C2;
    localparam logic [10:0] OP_STURB  = 11'h1C0;
    localparam logic [10:0] OP_LDURH  = 11'h3C2;
    localparam logic [10:0] OP_STURH  = 11'h3C0;
    localparam logic [10:0] OP_LDURSW = 11'h5C4;
    localparam logic [10:0] OP_STURW  = 11'h5C0;

    // IM-format, instr[31:23]
    localparam logic [8:0] OP_MOVZ = 9'h1A5;
    localparam logic [8:0] OP_MOVK = 9'h1E5;

    // I-format, instr[31:22]
    localparam logic [9:0] OP_ADDI  = 10'h244;
    localparam logic [9:0] OP_ADDIS = 10'h2C4;
    localparam logic [9:0] OP_SUBI  = 10'h344;
    localparam logic [9:0] OP_SUBIS = 10'h3C4;
    localparam logic [9:0] OP_ANDI  = 10'h248;
    localparam logic [9:0] OP_ANDIS = 10'h3C8;
    localparam logic [9:0] OP_ORRI  = 10'h2C8;
    localparam logic [9:0] OP_EORI  = 10'h348;

    // CB-format, instr[31:24]
    localparam logic [7:0] OP_CBZ   = 8'hB4;
    localparam logic [7:0] OP_CBNZ  = 8'hB5;
    localparam logic [7:0] OP_BCOND = 8'h54;

    // B-format, instr[31:26]
    localparam logic [5:0] OP_B  = 6'h05;
    localparam logic [5:0] OP_BL = 6'h25;

    localparam int unsigned NumRtype = 15;
    localparam logic [NumRtype-1:0][10:0] RtypeOps = {
        11'h458, 11'h558, 11'h658, 11'h758, 11'h450, 11'h750, 11'h550, 11'h650,
        11'h69B, 11'h69A, 11'h6B0, 11'h4D8, 11'h4D6, 11'h4DA, 11'h4DE
    };

    function automatic logic is_rtype(input logic [10:0] op);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < int'(NumRtype); i++) begin
            if (op == RtypeOps[i]) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational LEGv8 immediate decoder: instruction word to {imm, fmt, err}.
module imm_decode
    import legv8_pkg::*;
#(
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned BR_SHIFT = 1
) (
    input  logic [31:0]       instr_i,
    output logic [DATA_W-1:0] imm_o,
    output imm_fmt_e          fmt_o,
    output logic              err_o
);

    logic [DATA_W-1:0] d_sx;
    logic [DATA_W-1:0] i_zx;
    logic [DATA_W-1:0] cb_sx;
    logic [DATA_W-1:0] b_sx;
    logic [63:0]       im_wide;
    logic [1:0]        hw;

    assign d_sx    = {{(DATA_W-9){instr_i[20]}}, instr_i[20:12]};
    assign i_zx    = {{(DATA_W-12){1'b0}}, instr_i[21:10]};
    assign cb_sx   = {{(DATA_W-19){instr_i[23]}}, instr_i[23:5]};
    assign b_sx    = {{(DATA_W-26){instr_i[25]}}, instr_i[25:0]};
    assign hw      = instr_i[22:21];
    assign im_wide = {48'd0, instr_i[20:5]} << {hw, 4'b0000};

    // First match wins, top to bottom.
    always_comb begin
        imm_o = '0;
        fmt_o = FMT_NONE;
        err_o = 1'b0;
        if (instr_i[31:21] inside {OP_LDUR, OP_STUR, OP_LDURB, OP_STURB,
                                   OP_LDURH, OP_STURH, OP_LDURSW, OP_STURW}) begin
            imm_o = d_sx;
            fmt_o = FMT_D;
        end else if (instr_i[31:23] inside {OP_MOVZ, OP_MOVK}) begin
            fmt_o = FMT_IM;
            if (DATA_W == 32 && hw[1]) begin
                err_o = 1'b1;
            end else begin
                imm_o = im_wide[DATA_W-1:0];
            end
        end else if (instr_i[31:22] inside {OP_ADDI, OP_ADDIS, OP_SUBI, OP_SUBIS,
                                            OP_ANDI, OP_ANDIS, OP_ORRI, OP_EORI}) begin
            imm_o = i_zx;
            fmt_o = FMT_I;
        end else if (instr_i[31:24] inside {OP_CBZ, OP_CBNZ, OP_BCOND}) begin
            imm_o = (BR_SHIFT != 0) ? {cb_sx[DATA_W-3:0], 2'b00} : cb_sx;
            fmt_o = FMT_CB;
        end else if (instr_i[31:26] inside {OP_B, OP_BL}) begin
            imm_o = (BR_SHIFT != 0) ? {b_sx[DATA_W-3:0], 2'b00} : b_sx;
            fmt_o = FMT_B;
        end else begin
            err_o = !is_rtype(instr_i[31:21]);
        end
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decoder feeding a 2-entry skid buffer with valid/ready.
module imm_gen_pipe
    import legv8_pkg::*;
#(
    parameter int unsigned DATA_W       = 64,
    parameter int unsigned BR_SHIFT     = 1,
    parameter int unsigned FLAG_UNKNOWN = 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [31:0]       INSTRUCTION,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [DATA_W-1:0] IMM_OUT,
    output imm_fmt_e          IMM_FMT,
    output logic              IMM_ERR,
    output logic [31:0]       INSTR_OUT
);

    typedef struct packed {
        logic [DATA_W-1:0] imm;
        imm_fmt_e          fmt;
        logic              err;
        logic [31:0]       instr;
    } entry_t;

    localparam entry_t EntryRst = '{imm: '0, fmt: FMT_NONE, err: 1'b0, instr: '0};

    logic [DATA_W-1:0] dec_imm;
    imm_fmt_e          dec_fmt;
    logic              dec_err;
    entry_t            dec;

    entry_t a_q;
    entry_t b_q;
    occ_e   occ_q;
    logic   out_valid_q;
    logic   in_ready_q;
    logic   in_xfer;
    logic   out_xfer;

    imm_decode #(
        .DATA_W   (DATA_W),
        .BR_SHIFT (BR_SHIFT)
    ) u_decode (
        .instr_i (INSTRUCTION),
        .imm_o   (dec_imm),
        .fmt_o   (dec_fmt),
        .err_o   (dec_err)
    );

    assign dec = '{imm: dec_imm, fmt: dec_fmt, err: dec_err && (FLAG_UNKNOWN != 0),
                   instr: INSTRUCTION};

    assign in_xfer  = IN_VALID && in_ready_q;
    assign out_xfer = out_valid_q && OUT_READY;

    // IN_READY is registered from occupancy only, so OUT_READY never reaches it combinationally.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            occ_q       <= StEmpty;
            a_q         <= EntryRst;
            b_q         <= EntryRst;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            unique case (occ_q)
                StEmpty: begin
                    if (in_xfer) begin
                        a_q         <= dec;
                        occ_q       <= StOne;
                        out_valid_q <= 1'b1;
                    end
                end
                StOne: begin
                    if (in_xfer && out_xfer) begin
                        a_q <= dec;
                    end else if (in_xfer) begin
                        b_q        <= dec;
                        occ_q      <= StFull;
                        in_ready_q <= 1'b0;
                    end else if (out_xfer) begin
                        occ_q       <= StEmpty;
                        out_valid_q <= 1'b0;
                    end
                end
                StFull: begin
                    if (out_xfer) begin
                        a_q        <= b_q;
                        occ_q      <= StOne;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    occ_q       <= StEmpty;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign IN_READY  = in_ready_q;
    assign OUT_VALID = out_valid_q;
    assign IMM_OUT   = a_q.imm;
    assign IMM_FMT   = a_q.fmt;
    assign IMM_ERR   = a_q.err;
    assign INSTR_OUT = a_q.instr;

endmodule
